// File: rtl/isp_mode_ctrl.sv
// Frame-synchronous ISP display-mode / gamma selector driven by debounced buttons
// and UART command bytes; staged values are applied on the frame-start edge.
module isp_mode_ctrl #(
    parameter int MODE_NUM     = 7,
    parameter int MODE_W       = 4,
    parameter int GAMMA_NUM    = 4,
    parameter int GAMMA_W      = 2,
    parameter int GAMMA_RESET  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CMD_TIMEOUT  = 50_000_000,
    parameter int VSYNC_POL    = 1,
    parameter int FRAME_SYNC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               cmd_valid,
    input  logic [7:0]         cmd_data,
    input  logic               frame_vsync,
    output logic [MODE_W-1:0]  mode,
    output logic [GAMMA_W-1:0] gamma_type,
    output logic               mode_pending,
    output logic               cmd_ack,
    output logic               cmd_err
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TO_W = $clog2(CMD_TIMEOUT + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(CMD_TIMEOUT - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);
    localparam logic              VS_ACT    = (VSYNC_POL != 0);
    localparam logic              APPLY_NOW = (FRAME_SYNC == 0);

    typedef enum logic [1:0] {IDLE, ARG_M, ARG_G} cmd_state_t;

    // ---------------- synchronisers and debounce ----------------
    logic [1:0]      nxt_sync, prv_sync;
    logic [2:0]      vs_pipe;
    logic [DB_W-1:0] nxt_cnt, prv_cnt;
    logic            nxt_deb, prv_deb, nxt_deb_q, prv_deb_q;
    logic            nxt_step, prv_step;
    logic            vs_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            nxt_sync  <= '0;
            prv_sync  <= '0;
            vs_pipe   <= {3{~VS_ACT}};
            nxt_cnt   <= '0;
            prv_cnt   <= '0;
            nxt_deb   <= 1'b0;
            prv_deb   <= 1'b0;
            nxt_deb_q <= 1'b0;
            prv_deb_q <= 1'b0;
            nxt_step  <= 1'b0;
            prv_step  <= 1'b0;
        end else begin
            nxt_sync  <= {nxt_sync[0], btn_next};
            prv_sync  <= {prv_sync[0], btn_prev};
            vs_pipe   <= {vs_pipe[1:0], frame_vsync};
            nxt_deb_q <= nxt_deb;
            prv_deb_q <= prv_deb;
            nxt_step  <= nxt_deb & ~nxt_deb_q;
            prv_step  <= prv_deb & ~prv_deb_q;

            if (nxt_sync[1] == nxt_deb) begin
                nxt_cnt <= '0;
            end else if (nxt_cnt == DB_LAST) begin
                nxt_cnt <= '0;
                nxt_deb <= ~nxt_deb;
            end else begin
                nxt_cnt <= nxt_cnt + DB_W'(1);
            end

            if (prv_sync[1] == prv_deb) begin
                prv_cnt <= '0;
            end else if (prv_cnt == DB_LAST) begin
                prv_cnt <= '0;
                prv_deb <= ~prv_deb;
            end else begin
                prv_cnt <= prv_cnt + DB_W'(1);
            end
        end
    end

    assign vs_edge = (vs_pipe[1] == VS_ACT) && (vs_pipe[2] != VS_ACT);

    // ---------------- command FSM ----------------
    cmd_state_t      state, state_nx;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      digit;
    logic            is_digit, timeout;
    logic            ack_d, err_d;
    logic            cmd_inc, cmd_dec, cmd_mode_wr, cmd_gamma_wr;

    assign digit    = cmd_data - 8'h30;
    assign is_digit = (cmd_data >= 8'h30) && (cmd_data <= 8'h39);
    assign timeout  = (state != IDLE) && !cmd_valid && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE || cmd_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_data == "m")
                    state_nx = ARG_M;
                else if (cmd_valid && cmd_data == "g")
                    state_nx = ARG_G;
            end
            ARG_M, ARG_G: begin
                if (cmd_valid || timeout)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack_d        = 1'b0;
        err_d        = 1'b0;
        cmd_inc      = 1'b0;
        cmd_dec      = 1'b0;
        cmd_mode_wr  = 1'b0;
        cmd_gamma_wr = 1'b0;
        if (cmd_valid) begin
            case (state)
                IDLE: begin
                    case (cmd_data)
                        "+": begin cmd_inc = 1'b1; ack_d = 1'b1; end
                        "-": begin cmd_dec = 1'b1; ack_d = 1'b1; end
                        "m", "g": ;
                        "1", "2", "3": begin
                            if (32'(digit) < GAMMA_NUM) begin
                                cmd_gamma_wr = 1'b1;
                                ack_d        = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                ARG_M: begin
                    if (is_digit && 32'(digit) < MODE_NUM) begin
                        cmd_mode_wr = 1'b1;
                        ack_d       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ARG_G: begin
                    if (is_digit && 32'(digit) < GAMMA_NUM) begin
                        cmd_gamma_wr = 1'b1;
                        ack_d        = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- staging and apply ----------------
    logic [MODE_W-1:0]  next_mode, mode_inc, mode_dec;
    logic [GAMMA_W-1:0] next_gamma;
    logic               cmd_wr, btn_inc, btn_dec;

    assign mode_inc = (next_mode == MODE_LAST) ? '0 : next_mode + MODE_W'(1);
    assign mode_dec = (next_mode == '0) ? MODE_LAST : next_mode - MODE_W'(1);
    // Any command write masks a coincident button step; opposite steps cancel.
    assign cmd_wr  = cmd_inc | cmd_dec | cmd_mode_wr | cmd_gamma_wr;
    assign btn_inc = nxt_step & ~prv_step & ~cmd_wr;
    assign btn_dec = prv_step & ~nxt_step & ~cmd_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            next_mode    <= '0;
            next_gamma   <= GAMMA_W'(GAMMA_RESET);
            mode         <= '0;
            gamma_type   <= GAMMA_W'(GAMMA_RESET);
            mode_pending <= 1'b0;
            cmd_ack      <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            cmd_ack <= ack_d;
            cmd_err <= err_d;
            if (cmd_mode_wr)
                next_mode <= MODE_W'(digit);
            else if (cmd_inc || btn_inc)
                next_mode <= mode_inc;
            else if (cmd_dec || btn_dec)
                next_mode <= mode_dec;
            if (cmd_gamma_wr)
                next_gamma <= GAMMA_W'(digit);
            if (APPLY_NOW || vs_edge) begin
                mode       <= next_mode;
                gamma_type <= next_gamma;
            end
            mode_pending <= (next_mode != mode) || (next_gamma != gamma_type);
        end
    end

endmodule

// File: tb/tb_isp_mode_ctrl.sv
// Self-checking bench for isp_mode_ctrl: directed scenarios followed by random
// command/button/frame traffic scored against a byte-level behavioural model.
module tb_isp_mode_ctrl;

    localparam int MODE_NUM    = 7;
    localparam int GAMMA_NUM   = 4;
    localparam int GAMMA_RESET = 2;
    localparam int DEB         = 4;
    localparam int TMO         = 16;

    logic       clk = 1'b0;
    logic       reset, btn_next, btn_prev, cmd_valid, frame_vsync;
    logic [7:0] cmd_data;
    logic [3:0] mode;
    logic [1:0] gamma_type;
    logic       mode_pending, cmd_ack, cmd_err;

    isp_mode_ctrl #(
        .MODE_NUM    (MODE_NUM),
        .MODE_W      (4),
        .GAMMA_NUM   (GAMMA_NUM),
        .GAMMA_W     (2),
        .GAMMA_RESET (GAMMA_RESET),
        .DEBOUNCE_CYC(DEB),
        .CMD_TIMEOUT (TMO),
        .VSYNC_POL   (1),
        .FRAME_SYNC  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .frame_vsync (frame_vsync),
        .mode        (mode),
        .gamma_type  (gamma_type),
        .mode_pending(mode_pending),
        .cmd_ack     (cmd_ack),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Reference model: staged/applied values, pending argument kind
    // (0 none, 1 mode, 2 gamma) and idle cycles since the last byte.
    int m_next, m_gamma_next, m_mode, m_gamma, m_arg, m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!cmd_valid) m_idle++;
    endtask

    task automatic model_reset();
        m_next = 0; m_gamma_next = GAMMA_RESET;
        m_mode = 0; m_gamma = GAMMA_RESET;
        m_arg = 0;  m_idle = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("ack_in_reset", cmd_ack, 0);
        check("err_in_reset", cmd_err, 0);
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic model_byte(input logic [7:0] b, output logic ea, output logic ee);
        int arg, d;
        bit dig;
        arg = (m_arg != 0 && m_idle >= TMO) ? 0 : m_arg;
        dig = (b >= 8'h30 && b <= 8'h39);
        d   = int'(b) - 48;
        ea = 1'b0; ee = 1'b0; m_arg = 0;
        if (arg == 0) begin
            if (b == "+")      begin m_next = (m_next + 1) % MODE_NUM; ea = 1'b1; end
            else if (b == "-") begin m_next = (m_next + MODE_NUM - 1) % MODE_NUM; ea = 1'b1; end
            else if (b == "m") m_arg = 1;
            else if (b == "g") m_arg = 2;
            else if (d >= 1 && d <= 3 && d < GAMMA_NUM) begin m_gamma_next = d; ea = 1'b1; end
            else ee = 1'b1;
        end else begin
            if (dig && d < ((arg == 1) ? MODE_NUM : GAMMA_NUM)) begin
                if (arg == 1) m_next = d; else m_gamma_next = d;
                ea = 1'b1;
            end else ee = 1'b1;
        end
        m_idle = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ea, ee;
        model_byte(b, ea, ee);
        cmd_valid = 1'b1;
        cmd_data  = b;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        check($sformatf("ack_%c", b), cmd_ack, ea);
        check($sformatf("err_%c", b), cmd_err, ee);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input logic nxt, input logic prv);
        btn_next = nxt; btn_prev = prv;
        idle(10);
        btn_next = 1'b0; btn_prev = 1'b0;
        idle(10);
        if (nxt && !prv) m_next = (m_next + 1) % MODE_NUM;
        else if (prv && !nxt) m_next = (m_next + MODE_NUM - 1) % MODE_NUM;
    endtask

    // Vsync rises just after a clock edge; outputs must change on the third edge.
    task automatic apply_frame();
        frame_vsync = 1'b1;
        tick(); tick();
        check("pending_before", mode_pending, (m_next != m_mode) || (m_gamma_next != m_gamma));
        check("mode_hold", mode, m_mode);
        check("gamma_hold", gamma_type, m_gamma);
        tick();
        m_mode = m_next; m_gamma = m_gamma_next;
        check("mode_apply", mode, m_mode);
        check("gamma_apply", gamma_type, m_gamma);
        tick();
        check("pending_clear", mode_pending, 0);
        frame_vsync = 1'b0;
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [16] = '{"+", "-", "m", "g", "0", "1", "2", "3",
                                  "4", "5", "6", "7", "8", "9", "x", "z"};
        reset = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        cmd_valid = 1'b0; cmd_data = 8'h00; frame_vsync = 1'b0;
        model_reset();
        tick();

        do_reset();
        check("rst_mode", mode, 0);
        check("rst_gamma", gamma_type, GAMMA_RESET);
        check("rst_pending", mode_pending, 0);
        check("rst_ack", cmd_ack, 0);
        check("rst_err", cmd_err, 0);

        // Glitch shorter than the debounce window.
        btn_next = 1'b1; idle(3); btn_next = 1'b0; idle(10);
        check("glitch_pending", mode_pending, 0);
        apply_frame();

        // Seven presses of next: 1..6 then wrap to 0; then prev wraps back to 6.
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0);
            apply_frame();
        end
        press(1'b0, 1'b1);
        apply_frame();

        // Argument command staged, held until the frame edge.
        send_byte("m");
        send_byte("5");
        tick();
        check("ack_single_pulse", cmd_ack, 0);
        check("pending_set", mode_pending, 1);
        check("mode_waits", mode, m_mode);
        idle(5);
        apply_frame();

        // Command errors and timeout.
        send_byte("m"); send_byte("9");
        send_byte("x");
        send_byte("g"); send_byte("z");
        send_byte("+");
        send_byte("3");
        send_byte("g"); idle(20); send_byte("2");
        apply_frame();

        // Collisions.
        press(1'b1, 1'b1);
        check("both_btn_pending", mode_pending, 0);
        apply_frame();
        btn_prev = 1'b1;
        idle(7);
        send_byte("+");
        idle(3); btn_prev = 1'b0; idle(10);
        apply_frame();
        send_byte("g"); send_byte("3");
        send_byte("g"); send_byte("1");
        idle(2);
        apply_frame();

        // Reset in ARG_M with a pending change.
        send_byte("+");
        send_byte("m");
        do_reset();
        check("midrst_mode", mode, 0);
        check("midrst_gamma", gamma_type, GAMMA_RESET);
        check("midrst_pending", mode_pending, 0);
        check("midrst_ack", cmd_ack, 0);
        check("midrst_err", cmd_err, 0);
        send_byte("5");
        apply_frame();

        // Random traffic.
        for (int i = 0; i < 250; i++) begin
            int act;
            act = int'($urandom_range(11, 0));
            if (act <= 6) begin
                send_byte(pool[$urandom_range(15, 0)]);
                idle(int'($urandom_range(2, 0)));
            end else if (act == 7) begin
                send_byte(pool[$urandom_range(3, 2)]);
                idle(20 + int'($urandom_range(3, 0)));
            end else if (act == 8 || act == 9) begin
                apply_frame();
            end else begin
                press(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            end
        end
        apply_frame();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
